fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined core. It owns the PC, drives the instruction-memory address, and latches the fetched word into IF/ID for decode. It consumes `enable_stall` from the hazard detection unit and the branch redirect resolved in ID. It also detects HLT and freezes fetch.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 50 +++++
 tb/tb_fetch_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/branch inputs, imem port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
  logic        enable_stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] stall_count;
  modport master (
    input  enable_stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, stall_count
  );
  modport slave (
    output enable_stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted, stall_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch, IF/ID register, HLT freeze and stall counter
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);
  logic [15:0] pc, instr, pc_plus2_q, stall_cnt;
  logic        valid, halted;
  logic [15:0] pc_plus2;
  logic        fetch_is_hlt;
  assign pc_plus2     = pc + 16'd2;
  assign fetch_is_hlt = (bus.imem_data[15:12] == HLT_OPCODE) && !halted;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= '0;
      pc_plus2_q <= '0;
      valid      <= 1'b0;
      halted     <= 1'b0;
      stall_cnt  <= '0;
    end else if (bus.enable_stall) begin
      stall_cnt <= (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
    end else if (bus.branch_taken) begin
      // a HLT sitting in IF is squashed along with the rest of the wrong path
      pc         <= bus.branch_target;
      instr      <= '0;
      pc_plus2_q <= '0;
      valid      <= 1'b0;
    end else if (halted) begin
      instr      <= '0;
      pc_plus2_q <= '0;
      valid      <= 1'b0;
    end else begin
      instr      <= bus.imem_data;
      pc_plus2_q <= pc_plus2;
      valid      <= 1'b1;
      pc         <= fetch_is_hlt ? pc : pc_plus2;
      halted     <= fetch_is_hlt;
    end
  end
  assign bus.imem_addr      = pc;
  assign bus.if_id_instr    = instr;
  assign bus.if_id_pc_plus2 = pc_plus2_q;
  assign bus.if_id_valid    = valid;
  assign bus.halted         = halted;
  assign bus.stall_count    = stall_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with hand-computed expectations for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  fetch_stage_if bus ();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic [15:0] data, input logic stall, input logic br, input logic [15:0] tgt);
    bus.imem_data     = data;
    bus.enable_stall  = stall;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_ifid(input string tag, input logic [15:0] pc, input logic [15:0] ins, input logic [15:0] p2, input logic v);
    chk({tag, "_pc"}, {16'h0, bus.imem_addr}, {16'h0, pc});
    chk({tag, "_instr"}, {16'h0, bus.if_id_instr}, {16'h0, ins});
    chk({tag, "_pc2"}, {16'h0, bus.if_id_pc_plus2}, {16'h0, p2});
    chk({tag, "_valid"}, {31'h0, bus.if_id_valid}, {31'h0, v});
  endtask
  initial begin
    bus.imem_data = '0; bus.enable_stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    #1;
    chk_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("reset_halted", {31'h0, bus.halted}, 0);
    chk("reset_stall", {16'h0, bus.stall_count}, 0);
    @(negedge clk); rst = 0;
    tick(16'h1111, 0, 0, 16'h0);
    chk_ifid("seq1", 16'h0002, 16'h1111, 16'h0002, 1'b1);
    tick(16'h2222, 0, 0, 16'h0);
    chk_ifid("seq2", 16'h0004, 16'h2222, 16'h0004, 1'b1);
    tick(16'h9999, 1, 1, 16'h0080);
    tick(16'h9999, 1, 1, 16'h0080);
    chk_ifid("stall", 16'h0004, 16'h2222, 16'h0004, 1'b1);
    chk("stall_count2", {16'h0, bus.stall_count}, 2);
    tick(16'h3333, 0, 0, 16'h0);
    chk_ifid("seq3", 16'h0006, 16'h3333, 16'h0006, 1'b1);
    tick(16'h4444, 0, 0, 16'h0);
    chk_ifid("seq4", 16'h0008, 16'h4444, 16'h0008, 1'b1);
    tick(16'h5555, 0, 1, 16'h0040);
    chk_ifid("branch", 16'h0040, 16'h0000, 16'h0000, 1'b0);
    tick(16'h6666, 0, 0, 16'h0);
    chk_ifid("br_tgt", 16'h0042, 16'h6666, 16'h0042, 1'b1);
    tick(16'h7777, 0, 1, 16'h000A);
    chk_ifid("br_a", 16'h000A, 16'h0000, 16'h0000, 1'b0);
    tick(16'hF000, 0, 0, 16'h0);
    chk_ifid("hlt", 16'h000A, 16'hF000, 16'h000C, 1'b1);
    chk("hlt_flag", {31'h0, bus.halted}, 1);
    tick(16'h1234, 0, 0, 16'h0);
    chk_ifid("halted", 16'h000A, 16'h0000, 16'h0000, 1'b0);
    tick(16'hF000, 0, 0, 16'h0);
    chk_ifid("halted2", 16'h000A, 16'h0000, 16'h0000, 1'b0);
    chk("halted_sticky", {31'h0, bus.halted}, 1);
    tick(16'h1234, 0, 1, 16'h0020);
    chk_ifid("halt_br", 16'h0020, 16'h0000, 16'h0000, 1'b0);
    chk("halt_br_flag", {31'h0, bus.halted}, 1);
    tick(16'h1234, 1, 0, 16'h0);
    chk("stall_halted", {16'h0, bus.stall_count}, 3);
    bus.enable_stall = 0;
    #2 rst = 1;
    #1;
    chk_ifid("arst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("arst_halted", {31'h0, bus.halted}, 0);
    chk("arst_stall", {16'h0, bus.stall_count}, 0);
    @(negedge clk); rst = 0;
    tick(16'h7777, 0, 0, 16'h0);
    chk_ifid("resume", 16'h0002, 16'h7777, 16'h0002, 1'b1);
    tick(16'hF000, 0, 1, 16'h0100);
    chk_ifid("squash", 16'h0100, 16'h0000, 16'h0000, 1'b0);
    chk("squash_flag", {31'h0, bus.halted}, 0);
    tick(16'h1234, 0, 1, 16'hFFFE);
    tick(16'h0001, 0, 0, 16'h0);
    chk_ifid("wrap", 16'h0000, 16'h0001, 16'h0000, 1'b1);
    repeat (65534) tick(16'h0002, 1, 0, 16'h0);
    chk("stall_fffe", {16'h0, bus.stall_count}, 32'h0000_FFFE);
    tick(16'h0002, 1, 0, 16'h0);
    chk("stall_ffff", {16'h0, bus.stall_count}, 32'h0000_FFFF);
    repeat (3) tick(16'h0002, 1, 0, 16'h0);
    chk("stall_sat", {16'h0, bus.stall_count}, 32'h0000_FFFF);
    chk_ifid("stall_long", 16'h0000, 16'h0001, 16'h0000, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
